// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux N-channel registered selector.
package arb_mux_pkg;

  // Selection mode, mapped one-to-one onto the rr_en pin.
  typedef enum logic {
    SEL_EXPLICIT = 1'b0,
    SEL_RR       = 1'b1
  } sel_mode_e;

  // Output register occupancy; FULL is what drives out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Round-robin pointer successor: the channel after the winner, wrapping at n.
  function automatic int next_ptr(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Combinational rotating priority encoder: the first requester at or after ptr wins.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  // Scan offsets from highest to lowest so the smallest offset from ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel selector (explicit select or round-robin) feeding a one-entry
// valid/ready output register that sustains one word per cycle.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               rr_en,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  out_state_e       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic [SELW-1:0]  r_ptr;

  sel_mode_e        w_mode;
  logic             w_load;
  logic             w_sel_ok;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_rr_valid;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_gnt_valid;
  logic [WIDTH-1:0] w_gnt_data;

  assign w_mode    = sel_mode_e'(rr_en);
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_chan  = r_chan;

  // Register can accept a word when empty or when its current word drains now.
  assign w_load = !out_valid || out_ready;

  // Out-of-range explicit select must not grant (only reachable for non-power-of-two N).
  assign w_sel_ok = ({1'b0, sel} < (SELW + 1)'(N));

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .req       (in_valid),
    .ptr       (r_ptr),
    .gnt_idx   (w_rr_idx),
    .gnt_valid (w_rr_valid)
  );

  // Grant selection by mode; depends only on valids/select, never on data.
  always_comb begin
    w_gnt_idx   = '0;
    w_gnt_valid = 1'b0;
    if (w_mode == SEL_RR) begin
      w_gnt_idx   = w_rr_idx;
      w_gnt_valid = w_rr_valid;
    end else begin
      w_gnt_idx   = sel;
      w_gnt_valid = w_sel_ok && in_valid[sel];
    end
  end

  assign w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];

  // Ready goes only to the granted channel, and never while in reset.
  always_comb begin
    in_ready = '0;
    if (!reset && w_load && w_gnt_valid) in_ready[w_gnt_idx] = 1'b1;
  end

  // Output register FSM and round-robin pointer; a grant here implies a transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_gnt_valid) begin
        r_state <= ST_FULL;
        r_data  <= w_gnt_data;
        r_chan  <= w_gnt_idx;
        if (w_mode == SEL_RR) r_ptr <= SELW'(next_ptr(int'(w_gnt_idx), N));
      end else begin
        r_state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux (N=4, WIDTH=8) with directed vectors.
module tb_arb_mux;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               rr_en;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_q[$];

  arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_en     (rr_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    sb_q.push_back({8'(ch), d});
  endtask

  task automatic set_ch(input int i, input logic [7:0] d);
    in_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted output word is compared with the scoreboard head.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got chan=%0d data=%0h want nothing", out_chan, out_data);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        chk("sb_word", {8'(out_chan), out_data}, {16'h0, e});
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 4'hF; rr_en = 1'b1; sel = '0; out_ready = 1'b1;
    in_data = '0;
    for (int i = 0; i < N; i++) set_ch(i, 8'hE0 + 8'(i));

    // Reset with all channels requesting.
    #2 chk("rst_in_ready0", 32'(in_ready), 0);
    cyc(); chk("rst_in_ready1", 32'(in_ready), 0);
    cyc();
    reset = 1'b0; in_valid = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_chan", 32'(out_chan), 0);

    // Explicit select of channel 2.
    cyc();
    rr_en = 1'b0; sel = 2'd2; set_ch(2, 8'hA5); in_valid = 4'b0100;
    #1 chk("exp_in_ready", 32'(in_ready), 32'b0100);
    push(2, 8'hA5);
    cyc();
    chk("exp_out_data", 32'(out_data), 32'hA5);
    chk("exp_out_chan", 32'(out_chan), 2);
    in_valid = 4'b1011;
    #1 chk("exp_nogrant_ready", 32'(in_ready), 0);
    cyc();
    chk("exp_nogrant_valid", 32'(out_valid), 0);

    // Round-robin fairness, all channels valid for 8 cycles (ptr starts at 0).
    rr_en = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(i, 8'h10 + 8'(i));
    for (int k = 0; k < 8; k++) begin
      #1 chk("rr_in_ready", 32'(in_ready), 32'(1) << (k % 4));
      push(k % 4, 8'h10 + 8'(k % 4));
      cyc();
      chk("rr_out_valid", 32'(out_valid), 1);
    end
    in_valid = '0;
    cyc();
    chk("rr_drained", 32'(out_valid), 0);

    // Back-pressure: ch1 word held while consumer stalls (ptr 0 -> 2).
    set_ch(1, 8'h3C); in_valid = 4'b0010; out_ready = 1'b0;
    #1 chk("bp_load_ready", 32'(in_ready), 32'b0010);
    push(1, 8'h3C);
    cyc();
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_data", 32'(out_data), 32'h3C);
      chk("bp_out_valid", 32'(out_valid), 1);
      cyc();
    end
    // Drain and load in the same edge; ptr=2 so ch3 wins over ch2's absence.
    out_ready = 1'b1; in_valid = 4'b1000; set_ch(3, 8'hC3);
    #1 chk("bp_reload_ready", 32'(in_ready), 32'b1000);
    push(3, 8'hC3);
    cyc();
    chk("bp_out_chan", 32'(out_chan), 3);
    in_valid = '0;
    cyc();

    // Pointer wrap: ch2 grant sets ptr=3, then sparse {ch0,ch1}.
    set_ch(2, 8'h22); in_valid = 4'b0100;
    #1 chk("wrap_ch2_ready", 32'(in_ready), 32'b0100);
    push(2, 8'h22);
    cyc();
    set_ch(0, 8'h50); set_ch(1, 8'h51); in_valid = 4'b0011;
    #1 chk("wrap_ch0_ready", 32'(in_ready), 32'b0001);
    push(0, 8'h50);
    cyc();
    #1 chk("wrap_ch1_ready", 32'(in_ready), 32'b0010);
    push(1, 8'h51);
    cyc();
    in_valid = '0;
    cyc();

    // Mid-stream reset: ptr=2, ch0 word loaded and stalled, then dropped.
    set_ch(0, 8'h77); in_valid = 4'b0001; out_ready = 1'b0;
    #1 chk("mr_load_ready", 32'(in_ready), 32'b0001);
    cyc();
    chk("mr_full_valid", 32'(out_valid), 1);
    chk("mr_full_data", 32'(out_data), 32'h77);
    reset = 1'b1; in_valid = 4'b1111;
    #1 chk("mr_rst_ready", 32'(in_ready), 0);
    cyc();
    reset = 1'b0; in_valid = '0;
    #1 chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_out_data", 32'(out_data), 0);

    // Mode toggle: ptr reset to 0, then must survive explicit-mode transfers.
    for (int i = 0; i < N; i++) set_ch(i, 8'h60 + 8'(i));
    out_ready = 1'b1; in_valid = 4'b1111; rr_en = 1'b1;
    #1 chk("mt_ptr0_ready", 32'(in_ready), 32'b0001);
    push(0, 8'h60);
    cyc();
    rr_en = 1'b0; sel = 2'd3;
    #1 chk("mt_sel3_ready", 32'(in_ready), 32'b1000);
    push(3, 8'h63);
    cyc();
    sel = 2'd0;
    #1 chk("mt_sel0_ready", 32'(in_ready), 32'b0001);
    push(0, 8'h60);
    cyc();
    rr_en = 1'b1;
    #1 chk("mt_ptr_kept", 32'(in_ready), 32'b0010);
    push(1, 8'h61);
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    chk("mt_final_valid", 32'(out_valid), 0);
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
